salsa20_core_iter: RTL and testbench



---
 rtl/salsa20_core_iter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_salsa20_core_iter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/salsa20_core_iter.sv
// -----------------------------------------------------------------------------
// salsa20_core_iter
//
// Sequential Salsa20 hash core. A block accepted on the input handshake is
// iterated through DR_PER_CYCLE chained double rounds per clock until the
// configured round count is reached. The result is then fed forward: each
// 32-bit word of the round output is added (mod 2^32) to the matching word of
// the original input. The result waits on the output handshake until it is
// taken.
//
// Parameters:
//   ROUNDS        total Salsa20 rounds (8, 12 or 20). It must be divisible
//                 by 2*DR_PER_CYCLE.
//   DR_PER_CYCLE  double rounds evaluated per clock (1, 2 or 5).
//
// Optional build macro:
//   SALSA_RUNTIME_ROUNDS_EN  adds rounds_sel[1:0] (00:8, 01:12, 10/11:20
//                            rounds). It is sampled when a block is accepted.
//                            ROUNDS is ignored in this build, and
//                            DR_PER_CYCLE must be 1 or 2.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous reset, active-high
//   in_valid   in   1    d_in holds a block
//   in_ready   out  1    core can accept a block (IDLE)
//   d_in       in   512  input state, word i at [32*i+31:32*i]
//   out_valid  out  1    d_out holds a finished hash (DONE)
//   out_ready  in   1    downstream takes d_out
//   d_out      out  512  hash result, same word order as d_in
//   busy       out  1    rounds in progress (RUN)
//   rounds_sel in   2    runtime round select (macro builds only)
// -----------------------------------------------------------------------------
module salsa20_core_iter #(
    parameter int ROUNDS       = 20,
    parameter int DR_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] d_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] d_out,
    output logic         busy
`ifdef SALSA_RUNTIME_ROUNDS_EN
    ,
    input  logic [1:0]   rounds_sel
`endif
);

    typedef logic [15:0][31:0] words_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

`ifdef SALSA_RUNTIME_ROUNDS_EN
    // The counter is sized for the longest selectable block (20 rounds).
    localparam int N_MAX = 20 / (2 * DR_PER_CYCLE);

    if (!(DR_PER_CYCLE == 1 || DR_PER_CYCLE == 2)) begin : g_bad_dr
        $error("salsa20_core_iter: DR_PER_CYCLE must be 1 or 2 with runtime rounds");
    end
`else
    localparam int N_MAX = ROUNDS / (2 * DR_PER_CYCLE);

    if (!(DR_PER_CYCLE == 1 || DR_PER_CYCLE == 2 || DR_PER_CYCLE == 5)) begin : g_bad_dr
        $error("salsa20_core_iter: DR_PER_CYCLE must be 1, 2 or 5");
    end
    if (ROUNDS <= 0 || (ROUNDS % (2 * DR_PER_CYCLE)) != 0) begin : g_bad_rounds
        $error("salsa20_core_iter: ROUNDS must be a positive multiple of 2*DR_PER_CYCLE");
    end
`endif

    localparam int CNT_W = $clog2(N_MAX) + 1;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    // Quarter round on words (a, b, c, d) of the state, written back in place.
    function automatic words_t qr_at(input words_t s, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c,
                                     input logic [3:0] d);
        words_t      t;
        logic [31:0] y0;
        logic [31:0] y1;
        logic [31:0] y2;
        logic [31:0] y3;
        t    = s;
        y1   = s[b] ^ rotl(s[a] + s[d], 5'd7);
        y2   = s[c] ^ rotl(y1 + s[a], 5'd9);
        y3   = s[d] ^ rotl(y2 + y1, 5'd13);
        y0   = s[a] ^ rotl(y3 + y2, 5'd18);
        t[a] = y0;
        t[b] = y1;
        t[c] = y2;
        t[d] = y3;
        return t;
    endfunction

    // Column round followed by row round.
    function automatic words_t double_round(input words_t s);
        words_t t;
        t = s;
        t = qr_at(t, 4'd0,  4'd4,  4'd8,  4'd12);
        t = qr_at(t, 4'd5,  4'd9,  4'd13, 4'd1);
        t = qr_at(t, 4'd10, 4'd14, 4'd2,  4'd6);
        t = qr_at(t, 4'd15, 4'd3,  4'd7,  4'd11);
        t = qr_at(t, 4'd0,  4'd1,  4'd2,  4'd3);
        t = qr_at(t, 4'd5,  4'd6,  4'd7,  4'd4);
        t = qr_at(t, 4'd10, 4'd11, 4'd8,  4'd9);
        t = qr_at(t, 4'd15, 4'd12, 4'd13, 4'd14);
        return t;
    endfunction

    function automatic words_t dr_chain(input words_t s);
        words_t t;
        t = s;
        for (int i = 0; i < DR_PER_CYCLE; i++) begin
            t = double_round(t);
        end
        return t;
    endfunction

    // Feed-forward: independent 32-bit adds, carries never cross words.
    function automatic words_t add_words(input words_t a, input words_t b);
        words_t t;
        for (int i = 0; i < 16; i++) begin
            t[i[3:0]] = a[i[3:0]] + b[i[3:0]];
        end
        return t;
    endfunction

    fsm_t             state_q, state_d;
    words_t           work_q, work_d;
    words_t           saved_q, saved_d;
    words_t           dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] n_last_s;
    words_t           dr_next_s;

`ifdef SALSA_RUNTIME_ROUNDS_EN
    logic [CNT_W-1:0] n_last_q, n_last_d;

    // Index of the last RUN cycle for the selected round count.
    function automatic logic [CNT_W-1:0] sel_to_last(input logic [1:0] sel);
        int rounds_v;
        case (sel)
            2'b00:   rounds_v = 32'd8;
            2'b01:   rounds_v = 32'd12;
            default: rounds_v = 32'd20;
        endcase
        return CNT_W'(rounds_v / (2 * DR_PER_CYCLE) - 1);
    endfunction

    assign n_last_s = n_last_q;
`else
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_MAX - 1);

    assign n_last_s = N_LAST;
`endif

    assign dr_next_s = dr_chain(work_q);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign d_out     = dout_q;

    // Next-state, datapath and handshake flag logic for IDLE/RUN/DONE.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        saved_d     = saved_q;
        dout_d      = dout_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef SALSA_RUNTIME_ROUNDS_EN
        n_last_d    = n_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d     = d_in;
                    saved_d    = d_in;
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef SALSA_RUNTIME_ROUNDS_EN
                    n_last_d   = sel_to_last(rounds_sel);
`endif
                end else begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                work_d = dr_next_s;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == n_last_s) begin
                    dout_d      = add_words(dr_next_s, saved_q);
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // d_out is not cleared on release; it keeps the last hash.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q      <= 512'd0;
            saved_q     <= 512'd0;
            dout_q      <= 512'd0;
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SALSA_RUNTIME_ROUNDS_EN
            n_last_q    <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            saved_q     <= saved_d;
            dout_q      <= dout_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SALSA_RUNTIME_ROUNDS_EN
            n_last_q    <= n_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_salsa20_core_iter.sv
// -----------------------------------------------------------------------------
// Testbench for salsa20_core_iter.
// A word-level Salsa20 model (quarter round, column/row rounds with index
// formulas, feed-forward) predicts every hash, and a cycle-countdown model
// predicts the handshake outputs of the DR_PER_CYCLE=1 instance on every
// cycle. Two further instances (DR_PER_CYCLE=2 and 5) are checked for latency
// and result on the golden vector.
// -----------------------------------------------------------------------------
module tb_salsa20_core_iter;

    typedef logic [15:0][31:0] words_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] d_in;
    logic         in_ready, out_valid, busy;
    logic [511:0] d_out;
    logic         in_ready2, out_valid2, busy2;
    logic [511:0] d_out2;
`ifndef SALSA_RUNTIME_ROUNDS_EN
    logic         in_ready5, out_valid5, busy5;
    logic [511:0] d_out5;
`else
    logic [1:0]   rounds_sel;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    salsa20_core_iter #(.ROUNDS(20), .DR_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready),
        .d_out(d_out), .busy(busy)
`ifdef SALSA_RUNTIME_ROUNDS_EN
        , .rounds_sel(rounds_sel)
`endif
    );

    salsa20_core_iter #(.ROUNDS(20), .DR_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .d_in(d_in), .out_valid(out_valid2), .out_ready(out_ready),
        .d_out(d_out2), .busy(busy2)
`ifdef SALSA_RUNTIME_ROUNDS_EN
        , .rounds_sel(rounds_sel)
`endif
    );

`ifndef SALSA_RUNTIME_ROUNDS_EN
    salsa20_core_iter #(.ROUNDS(20), .DR_PER_CYCLE(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
        .d_in(d_in), .out_valid(out_valid5), .out_ready(out_ready),
        .d_out(d_out5), .busy(busy5)
    );
`endif

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Salsa20 reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [3:0][31:0] qr(input logic [3:0][31:0] y);
        logic [3:0][31:0] z;
        z[1] = y[1] ^ rotl(y[0] + y[3], 7);
        z[2] = y[2] ^ rotl(z[1] + y[0], 9);
        z[3] = y[3] ^ rotl(z[2] + z[1], 13);
        z[0] = y[0] ^ rotl(z[3] + z[2], 18);
        return z;
    endfunction

    // Column c starts on the diagonal (5c) and walks down by 4 words.
    function automatic words_t col_round(input words_t s);
        words_t t = s;
        logic [3:0][31:0] y, z;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) y[k] = s[(5 * c + 4 * k) % 16];
            z = qr(y);
            for (int k = 0; k < 4; k++) t[(5 * c + 4 * k) % 16] = z[k];
        end
        return t;
    endfunction

    // Row r starts on the diagonal and walks right, wrapping within the row.
    function automatic words_t row_round(input words_t s);
        words_t t = s;
        logic [3:0][31:0] y, z;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) y[k] = s[4 * r + (r + k) % 4];
            z = qr(y);
            for (int k = 0; k < 4; k++) t[4 * r + (r + k) % 4] = z[k];
        end
        return t;
    endfunction

    function automatic words_t salsa_hash(input words_t x, input int rounds);
        words_t s = x;
        for (int r = 0; r < rounds / 2; r++) s = row_round(col_round(s));
        for (int i = 0; i < 16; i++) s[i] = s[i] + x[i];
        return s;
    endfunction

    function automatic int cur_rounds();
`ifdef SALSA_RUNTIME_ROUNDS_EN
        case (rounds_sel)
            2'b00:   return 8;
            2'b01:   return 12;
            default: return 20;
        endcase
`else
        return 20;
`endif
    endfunction

    // ---------------- cycle model of the DR_PER_CYCLE=1 instance ----------------
    words_t m_dout = '0;
    words_t m_pend = '0;
    bit     m_on = 1'b0, m_rdy = 1'b0, m_ov = 1'b0, m_busy = 1'b0;
    int     m_left = -1;

    always @(posedge clk) begin
        if (rst) begin
            m_on   <= 1'b1;
            m_rdy  <= 1'b1;
            m_ov   <= 1'b0;
            m_busy <= 1'b0;
            m_left <= -1;
            m_dout <= '0;
        end else if (m_rdy && in_valid) begin
            m_pend <= salsa_hash(d_in, cur_rounds());
            m_left <= cur_rounds() / 2;
            m_rdy  <= 1'b0;
            m_busy <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_ov   <= 1'b1;
                m_busy <= 1'b0;
                m_dout <= m_pend;
            end
        end else if (m_ov && out_ready) begin
            m_ov  <= 1'b0;
            m_rdy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("cyc_in_ready", in_ready, m_rdy);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_out_valid", out_valid, m_ov);
            chk("cyc_d_out", d_out, m_dout);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [511:0] blk);
        in_valid = 1'b1;
        d_in     = blk;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        d_in     = ~blk;
    endtask

    task automatic wait_main(input int budget, output int lat);
        lat = 0;
        while (!out_valid && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    words_t g, p, ec, er, e1, e2, e5, held, b3, b4;
    words_t b5 [3];
    words_t res [$];
    logic [3:0][31:0] qy, qz;
    int lat, l1, l2, l5, k, cyc;
    int acc [3];
    bit rdy_b, ov_seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; d_in = '0;
`ifdef SALSA_RUNTIME_ROUNDS_EN
        rounds_sel = 2'b10;
`endif
        // Pin the model against hand-computed Salsa20 values.
        qy = {32'h0, 32'h0, 32'h0, 32'h1};
        qz = {32'h20500000, 32'h00010200, 32'h00000080, 32'h08008145};
        chk("pin_qr", qr(qy), qz);
        p = '0; p[0] = 32'h1; p[4] = 32'h1; p[8] = 32'h1; p[12] = 32'h1;
        ec = '0;
        ec[0] = 32'h10090288; ec[4] = 32'h00000101; ec[8] = 32'h00020401; ec[12] = 32'h40a04001;
        chk("pin_colround", col_round(p), ec);
        er[0]  = 32'h08008145; er[1]  = 32'h00000080; er[2]  = 32'h00010200; er[3]  = 32'h20500000;
        er[4]  = 32'h20100001; er[5]  = 32'h00048044; er[6]  = 32'h00000080; er[7]  = 32'h00010000;
        er[8]  = 32'h00000001; er[9]  = 32'h00002000; er[10] = 32'h80040000; er[11] = 32'h00000000;
        er[12] = 32'h00000001; er[13] = 32'h00000200; er[14] = 32'h00402000; er[15] = 32'h88000100;
        chk("pin_rowround", row_round(p), er);

        g = '0; g[0] = 32'hdeadbeef; g[8] = 32'hfeedface;
        for (int i = 0; i < 16; i++) begin
            b3[i] = 32'h13579bdf * (i + 3);
            b4[i] = 32'h2468ace0 ^ (i * 32'h01010101);
            for (int j = 0; j < 3; j++) b5[j][i] = 32'h9e3779b9 * (i + 1) + 32'h1000 * (j + 1);
        end

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: zero input
        send(512'd0);
        wait_main(15, lat);
        chk("s1_latency", lat, 10);
        chk("s1_zero_hash", d_out, 512'd0);
        @(posedge clk); #1;

        // 2: golden vector on all DR_PER_CYCLE variants, held in DONE
        out_ready = 1'b0;
        send(g);
        l1 = -1; l2 = -1; l5 = -1;
`ifdef SALSA_RUNTIME_ROUNDS_EN
        l5 = 2;
`endif
        for (int c = 1; c <= 15 && l1 < 0; c++) begin
            @(posedge clk); #1;
            if (out_valid && l1 < 0) begin l1 = c; e1 = d_out; end
            if (out_valid2 && l2 < 0) begin l2 = c; e2 = d_out2; end
`ifndef SALSA_RUNTIME_ROUNDS_EN
            if (out_valid5 && l5 < 0) begin l5 = c; e5 = d_out5; end
`endif
        end
        chk("s2_lat_dr1", l1, 10);
        chk("s2_lat_dr2", l2, 5);
        chk("s2_lat_dr5", l5, 2);
        chk("s2_hash_dr1", e1, salsa_hash(g, 20));
        chk("s2_hash_dr2", e2, salsa_hash(g, 20));
`ifndef SALSA_RUNTIME_ROUNDS_EN
        chk("s2_hash_dr5", e5, salsa_hash(g, 20));
`endif

        // 3: backpressure, a new block offered while DONE
        held = d_out;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) begin in_valid = 1'b1; d_in = b3; end
            else begin in_valid = 1'b0; end
            @(posedge clk); #1;
            chk("s3_in_ready_low", in_ready, 1'b0);
            chk("s3_d_out_stable", d_out, held);
            chk("s3_out_valid_held", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("s3_release_in_ready", in_ready, 1'b1);
        chk("s3_release_out_valid", out_valid, 1'b0);
        chk("s3_not_accepted", busy, 1'b0);

        // 4: reset on the 4th RUN edge
        send(b4);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("s4_in_ready", in_ready, 1'b1);
        chk("s4_busy", busy, 1'b0);
        chk("s4_out_valid", out_valid, 1'b0);
        chk("s4_d_out", d_out, 512'd0);
        ov_seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen = 1'b1;
        end
        chk("s4_no_out_valid", ov_seen, 1'b0);

        // 5: back-to-back blocks
        in_valid = 1'b1; d_in = b5[0]; k = 0; cyc = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        while ((k < 3 || res.size() < 3) && cyc < 80) begin
            rdy_b = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy_b && in_valid) begin
                acc[k] = cyc;
                k++;
                if (k < 3) d_in = b5[k];
                else in_valid = 1'b0;
            end
            if (out_valid) res.push_back(d_out);
        end
        in_valid = 1'b0;
        chk("s5_pulses", res.size(), 3);
        for (int j = 0; j < 3; j++) begin
            if (j < res.size()) chk("s5_result", res[j], salsa_hash(b5[j], 20));
        end
        chk("s5_spacing_01", acc[1] - acc[0], 12);
        chk("s5_spacing_12", acc[2] - acc[1], 12);
        repeat (2) @(posedge clk);
        #1;

`ifdef SALSA_RUNTIME_ROUNDS_EN
        // 6: runtime round selection, first block changes rounds_sel mid-RUN
        for (int i = 0; i < 3; i++) begin
            rounds_sel = (i == 0) ? 2'b00 : ((i == 1) ? 2'b01 : 2'b10);
            send(g);
            if (i == 0) rounds_sel = 2'b10;
            wait_main(15, lat);
            chk("s6_latency", lat, (i == 0) ? 4 : ((i == 1) ? 6 : 10));
            chk("s6_hash", d_out, salsa_hash(g, (i == 0) ? 8 : ((i == 1) ? 12 : 20)));
            @(posedge clk); #1;
        end
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
